csr_timer_bank: RTL
===================

Name: csr_timer_bank

Overview:
Parametrised machine-timer CSR block: one free-running CNT_W-bit time counter with programmable prescaler and NUM_CH independent compare channels. Each channel has a sticky pending bit and an enable, and drives its own interrupt line. Sits beside the core CSR register file on the same CSR read/writeback bus. Decodes its own CSR window and replaces the single fixed-compare timer with a multi-channel, prescaled, atomically readable one.

Parameters:
NUM_CH, 3, number of compare channels (1..8)
CNT_W, 64, time counter and compare width (33..64)
PRESC_W, 8, prescaler reload width (1..16)
BASE_ADDR, 12'h7d0, first CSR address of the window (16-aligned)

Ports:
clk  input  1  clock
nrst  input  1  reset; asynchronous, active-low
csr_re  input  1  CSR read strobe, qualifies csr_address_r for the snapshot side effect
csr_address_r  input  12  CSR read address
csr_we  input  1  CSR write enable
csr_address_wb  input  12  CSR writeback address
csr_wb  input  32  CSR writeback data
exception_pending  input  1  when 1, all CSR writes are dropped
csr_data  output  32  combinational read data
csr_hit_r  output  1  csr_address_r lies in a mapped address of this window
irq_o  output  NUM_CH  per-channel interrupt (pending & enable)
irq_any  output  1  OR of irq_o
tick_o  output  1  registered 1-cycle pulse on each time increment

Behaviour:
- Address map (offsets from BASE_ADDR):
  - +0 time[31:0]; +1 time[CNT_W-1:32] zero-extended.
  - +2 CTRL: bit0 EN; bits[8+PRESC_W-1:8] PRESC.
  - +3 PEND: read pending[NUM_CH-1:0]; write-1-to-clear.
  - +4 IE: per-channel enable.
  - +5 time-hi snapshot, read-only.
  - +8+2k cmp[k] low word; +9+2k cmp[k] high word.
- Unmapped offsets, and channels k>=NUM_CH: read 0, csr_hit_r=0, writes ignored.
- Writes take effect only when csr_we=1 and exception_pending=0.
- Reset values: time=0, presc_cnt=0, EN=0, PRESC=0, IE=0, pending=0, snapshot=0, irq_o=0, irq_any=0, tick_o=0.
- Reset values of cmp[k]: all ones, so no channel fires after reset.
- Prescaler:
  - When EN=1, presc_cnt counts 0..PRESC.
  - tick is asserted in the cycle presc_cnt==PRESC; presc_cnt then wraps to 0. PRESC=0 gives a tick every cycle.
  - EN=0 holds presc_cnt and time.
  - Any write to CTRL clears presc_cnt.
- Time counter:
  - Increments by 1 on tick, modulo 2^CNT_W (all ones wraps to 0, no flag).
  - A CSR write to time lo or hi replaces that word; the increment is suppressed in the write cycle. Write has priority over tick.
  - tick_o is tick registered (1 cycle later).
- Atomic read: when csr_re=1 and csr_address_r=+0, the snapshot register captures time high bits at the clock edge. Software reads +0 then +5 to get a coherent 64-bit value. A read of +1 does not touch the snapshot.
- Compare and pending:
  - match[k] = (time >= cmp[k]), unsigned, over CNT_W bits, evaluated on the current registered values.
  - pending[k] is set at the next edge when match[k]=1.
  - A write to cmp[k] lo or hi suppresses setting pending[k] in that same cycle, so there is no spurious fire between half-writes.
  - W1C clear and a set in the same cycle: set wins.
  - If match persists after a clear, pending re-asserts one cycle later.
  - Writing a larger cmp does not clear pending; software must W1C it.
- Interrupts: irq_o[k] = pending[k] & IE[k], combinational from registers. irq_any = |irq_o.
- Latency: time reaching cmp -> pending, and hence irq_o, asserts 1 cycle later.
- Reset mid-operation: all state returns to reset values immediately, and irq_o drops asynchronously.

Test Plan:
- Reset, then read +2, +3, +4, +0 -> 0 each; read +8 -> 32'hFFFFFFFF; irq_o=0.
- Write CTRL=32'h0000_0301 (EN=1, PRESC=3) -> tick_o pulses every 4 cycles; after 40 cycles, time=10.
- PRESC=0, EN=1; write cmp0 lo=20, hi=0; IE=1 -> pending[0]/irq_o[0] rise the cycle after time==20; irq_any=1.
- Write PEND=1 while time>=cmp0 -> pending stays 1. Then set cmp0 hi=1 and W1C -> pending=0 and stays 0.
- Write time lo/hi=32'hFFFFFFFF with EN=1 -> next tick gives time=0; with CNT_W=40, hi read returns 32'h000000FF before the wrap.
- Assert csr_re at +0 while time=0x1_FFFF_FFFF; lo rolls over before the +5 read -> +5 still returns 1.
- Any write with exception_pending=1 -> register unchanged.

Source files
------------

// File: rtl/csr_timer_bank_if.sv
// CSR read/writeback bus shared by the core register file and the timer bank.
// The core drives addresses and write data; the timer returns read data and a hit flag.
interface csr_timer_bank_if;
    logic        csr_re;
    logic [11:0] csr_address_r;
    logic        csr_we;
    logic [11:0] csr_address_wb;
    logic [31:0] csr_wb;
    logic        exception_pending;
    logic [31:0] csr_data;
    logic        csr_hit_r;

    modport master (
        output csr_re, csr_address_r, csr_we, csr_address_wb, csr_wb, exception_pending,
        input  csr_data, csr_hit_r
    );

    modport slave (
        input  csr_re, csr_address_r, csr_we, csr_address_wb, csr_wb, exception_pending,
        output csr_data, csr_hit_r
    );
endinterface

// File: rtl/csr_timer_bank.sv
// Machine-timer CSR block: prescaled free-running time counter, NUM_CH compare
// channels with sticky pending bits, and a coherent-read snapshot of the time high word.
module csr_timer_bank #(
    parameter int          NUM_CH    = 3,
    parameter int          CNT_W     = 64,
    parameter int          PRESC_W   = 8,
    parameter logic [11:0] BASE_ADDR = 12'h7d0
) (
    input  logic                clk,
    input  logic                nrst,
    csr_timer_bank_if.slave     bus,
    output logic [NUM_CH-1:0]   irq_o,
    output logic                irq_any,
    output logic                tick_o
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0]   r_time;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [PRESC_W-1:0] r_presc;
    logic               r_en;
    logic [NUM_CH-1:0]  r_ie;
    logic [NUM_CH-1:0]  r_pend;
    logic [31:0]        r_snap;
    logic               r_tick_o;
    logic [CNT_W-1:0]   r_cmp [NUM_CH];

    logic [11:0]        w_rd_off;
    logic [11:0]        w_wr_off;
    logic               w_wr;
    logic               w_wr_time_lo;
    logic               w_wr_time_hi;
    logic               w_wr_ctrl;
    logic               w_wr_pend;
    logic               w_wr_ie;
    logic               w_tick;
    logic [31:0]        w_time_hi;
    logic [NUM_CH-1:0]  w_cmp_wr_lo;
    logic [NUM_CH-1:0]  w_cmp_wr_hi;
    logic [NUM_CH-1:0]  w_pend_nxt;

    assign w_rd_off     = bus.csr_address_r - BASE_ADDR;
    assign w_wr_off     = bus.csr_address_wb - BASE_ADDR;
    assign w_wr         = bus.csr_we & ~bus.exception_pending;
    assign w_wr_time_lo = w_wr && (w_wr_off == 12'd0);
    assign w_wr_time_hi = w_wr && (w_wr_off == 12'd1);
    assign w_wr_ctrl    = w_wr && (w_wr_off == 12'd2);
    assign w_wr_pend    = w_wr && (w_wr_off == 12'd3);
    assign w_wr_ie      = w_wr && (w_wr_off == 12'd4);

    assign w_tick    = r_en && (r_presc_cnt == r_presc);
    assign w_time_hi = 32'(r_time[CNT_W-1:32]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cmp_wr_lo = '0;
        w_cmp_wr_hi = '0;
        w_pend_nxt  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cmp_wr_lo[k] = w_wr && (w_wr_off == 12'(8 + 2 * k));
            w_cmp_wr_hi[k] = w_wr && (w_wr_off == 12'(9 + 2 * k));
            // A compare half-write blocks the set so a half-updated cmp never fires.
            w_pend_nxt[k]  = ((r_time >= r_cmp[k]) && !(w_cmp_wr_lo[k] || w_cmp_wr_hi[k]))
                           || (r_pend[k] && !(w_wr_pend && bus.csr_wb[k]));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_time      <= '0;
            r_presc_cnt <= '0;
            r_presc     <= '0;
            r_en        <= 1'b0;
            r_ie        <= '0;
            r_pend      <= '0;
            r_snap      <= '0;
            r_tick_o    <= 1'b0;
        end else begin
            r_tick_o <= w_tick;
            r_pend   <= w_pend_nxt;

            if (w_wr_ctrl) begin
                r_en        <= bus.csr_wb[0];
                r_presc     <= bus.csr_wb[8 +: PRESC_W];
                r_presc_cnt <= '0;
            end else if (w_tick) begin
                r_presc_cnt <= '0;
            end else if (r_en) begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end

            if (w_wr_time_lo) begin
                r_time[31:0] <= bus.csr_wb;
            end else if (w_wr_time_hi) begin
                r_time[CNT_W-1:32] <= bus.csr_wb[HI_W-1:0];
            end else if (w_tick) begin
                r_time <= r_time + CNT_W'(1);
            end

            if (w_wr_ie) begin
                r_ie <= bus.csr_wb[NUM_CH-1:0];
            end

            if (bus.csr_re && (w_rd_off == 12'd0)) begin
                r_snap <= w_time_hi;
            end
        end
    end

    // NOTE: compare registers are reset to all ones on purpose, so no channel matches out of reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_cmp[k] <= '1;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_cmp_wr_lo[k]) begin
                    r_cmp[k][31:0] <= bus.csr_wb;
                end else if (w_cmp_wr_hi[k]) begin
                    r_cmp[k][CNT_W-1:32] <= bus.csr_wb[HI_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.csr_data  = '0;
        bus.csr_hit_r = 1'b0;
        case (w_rd_off)
            12'd0: begin bus.csr_hit_r = 1'b1; bus.csr_data = r_time[31:0]; end
            12'd1: begin bus.csr_hit_r = 1'b1; bus.csr_data = w_time_hi; end
            12'd2: begin bus.csr_hit_r = 1'b1; bus.csr_data = (32'(r_presc) << 8) | 32'(r_en); end
            12'd3: begin bus.csr_hit_r = 1'b1; bus.csr_data = 32'(r_pend); end
            12'd4: begin bus.csr_hit_r = 1'b1; bus.csr_data = 32'(r_ie); end
            12'd5: begin bus.csr_hit_r = 1'b1; bus.csr_data = r_snap; end
            default: begin
                // Offsets 6..7 and channels beyond NUM_CH fall through as unmapped.
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_rd_off == 12'(8 + 2 * k)) begin
                        bus.csr_hit_r = 1'b1;
                        bus.csr_data  = r_cmp[k][31:0];
                    end else if (w_rd_off == 12'(9 + 2 * k)) begin
                        bus.csr_hit_r = 1'b1;
                        bus.csr_data  = 32'(r_cmp[k][CNT_W-1:32]);
                    end
                end
            end
        endcase
    end

    assign irq_o   = r_pend & r_ie;
    assign irq_any = |irq_o;
    assign tick_o  = r_tick_o;

endmodule
